// File: rtl/dm_if_pkg.sv
// Shared encodings for the MEM-stage data-memory requester: access sizes,
// controller states and the alignment rule.
package dm_if_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // Size 11 never maps to a lane; halves and words must sit on their natural boundary.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = addr_lo[0];
            SIZE_W:  bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extracts/extends a load result from a memory word
// and merges sub-word store data into the word read back for read-modify-write.
module mem_lane_align
    import dm_if_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] ld_ext,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Load lane select and sign/zero extension.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (size)
            SIZE_B:  ld_ext = is_signed ? {{24{byte_s[7]}}, byte_s} : {24'h000000, byte_s};
            SIZE_H:  ld_ext = is_signed ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
            SIZE_W:  ld_ext = word;
            default: ld_ext = 32'h0000_0000;
        endcase
    end

    // Store merge: only the addressed lane(s) take new data, the rest keep the read value.
    always_comb begin
        merged_word = word;
        case (size)
            SIZE_B: begin
                case (addr_lo)
                    2'd0:    merged_word[7:0]   = wdata[7:0];
                    2'd1:    merged_word[15:8]  = wdata[7:0];
                    2'd2:    merged_word[23:16] = wdata[7:0];
                    2'd3:    merged_word[31:24] = wdata[7:0];
                    default: merged_word = word;
                endcase
            end
            SIZE_H: begin
                if (addr_lo[1]) begin
                    merged_word[31:16] = wdata[15:0];
                end else begin
                    merged_word[15:0] = wdata[15:0];
                end
            end
            SIZE_W:  merged_word = wdata;
            default: merged_word = word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage requester for a word-only DMEM: byte/half/word loads, sub-word stores
// by read-modify-write, pipeline stall until the access completes.
module mem_access_ctrl
    import dm_if_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic              misalign,
    output logic [ADDR_W-1:0] dm_R_addr,
    output logic              dm_MemRead,
    input  logic [31:0]       dm_R_data,
    output logic [ADDR_W-1:0] dm_W_addr,
    output logic              dm_MemWrite,
    output logic [31:0]       dm_W_data
);

    state_e              state_r;
    state_e              state_nxt_s;
    logic                accept_s;
    logic                illegal_s;

    logic                we_r;
    logic [1:0]          size_r;
    logic                signed_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;

    logic [31:0]         ld_ext_s;
    logic [31:0]         merged_s;

    logic                ld_valid_r;
    logic [31:0]         ld_data_r;
    logic                misalign_r;
    logic [ADDR_W-1:0]   r_addr_r;
    logic                mem_read_r;
    logic [ADDR_W-1:0]   w_addr_r;
    logic                mem_write_r;
    logic [31:0]         w_data_r;

    assign accept_s  = (state_r == ST_IDLE) & req_valid;
    assign illegal_s = is_illegal(req_size, req_addr[1:0]);

    // The pipeline may advance only in the response cycle.
    assign stall = req_valid & (state_r != ST_RESP);

    mem_lane_align u_align (
        .word        (dm_R_data),
        .addr_lo     (addr_r[1:0]),
        .size        (size_r),
        .is_signed   (signed_r),
        .wdata       (wdata_r),
        .ld_ext      (ld_ext_s),
        .merged_word (merged_s)
    );

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!req_valid) begin
                    state_nxt_s = ST_IDLE;
                end else if (illegal_s) begin
                    state_nxt_s = ST_RESP;
                end else if (req_we && (req_size == SIZE_W)) begin
                    state_nxt_s = ST_WR;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_RD: begin
                if (we_r) begin
                    state_nxt_s = ST_WR;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_WR:   state_nxt_s = ST_RESP;
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latch; the pipeline holds its inputs, but the latch keeps the access self-contained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r     <= 1'b0;
            size_r   <= 2'b00;
            signed_r <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            we_r     <= req_we;
            size_r   <= req_size;
            signed_r <= req_signed;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
        end
    end

    // Registered DMEM drivers and response pulses, decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_r    <= {ADDR_W{1'b0}};
            mem_read_r  <= 1'b0;
            w_addr_r    <= {ADDR_W{1'b0}};
            mem_write_r <= 1'b0;
            w_data_r    <= 32'h0000_0000;
            ld_valid_r  <= 1'b0;
            ld_data_r   <= 32'h0000_0000;
            misalign_r  <= 1'b0;
        end else begin
            mem_read_r  <= (state_nxt_s == ST_RD);
            mem_write_r <= (state_nxt_s == ST_WR);
            ld_valid_r  <= (state_r == ST_RD) & ~we_r;
            misalign_r  <= accept_s & illegal_s;
            if (accept_s && (state_nxt_s == ST_RD)) begin
                r_addr_r <= req_addr;
            end
            // Write address/data change only when entering WR so they are stable all through it.
            if (accept_s && (state_nxt_s == ST_WR)) begin
                w_addr_r <= req_addr;
                w_data_r <= req_wdata;
            end else if ((state_r == ST_RD) && we_r) begin
                w_addr_r <= addr_r;
                w_data_r <= merged_s;
            end
            if ((state_r == ST_RD) && !we_r) begin
                ld_data_r <= ld_ext_s;
            end
        end
    end

    assign dm_R_addr   = r_addr_r;
    assign dm_MemRead  = mem_read_r;
    assign dm_W_addr   = w_addr_r;
    assign dm_MemWrite = mem_write_r;
    assign dm_W_data   = w_data_r;
    assign ld_valid    = ld_valid_r;
    assign ld_data     = ld_data_r;
    assign misalign    = misalign_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: word-addressed DMEM model, a request-level
// reference model driving per-cycle expectations, and literal checks on load results.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        misalign;
    logic [6:0]  dm_R_addr;
    logic        dm_MemRead;
    logic [31:0] dm_R_data;
    logic [6:0]  dm_W_addr;
    logic        dm_MemWrite;
    logic [31:0] dm_W_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] dmem [0:31];
    logic [31:0] model_mem [0:31];

    logic        exp_stall  = 1'b0;
    logic        exp_rd     = 1'b0;
    logic        exp_wr     = 1'b0;
    logic        exp_ldv    = 1'b0;
    logic        exp_mis    = 1'b0;
    logic [6:0]  exp_r_addr = 7'd0;
    logic [6:0]  exp_w_addr = 7'd0;
    logic [31:0] exp_w_data = 32'd0;
    logic [31:0] exp_ld     = 32'd0;

    mem_access_ctrl #(.ADDR_W(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .misalign    (misalign),
        .dm_R_addr   (dm_R_addr),
        .dm_MemRead  (dm_MemRead),
        .dm_R_data   (dm_R_data),
        .dm_W_addr   (dm_W_addr),
        .dm_MemWrite (dm_MemWrite),
        .dm_W_data   (dm_W_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-only DMEM: combinational read, write on the clock while MemWrite is high.
    assign dm_R_data = dmem[dm_R_addr[6:2]];
    always @(posedge clk) begin
        if (dm_MemWrite) dmem[dm_W_addr[6:2]] <= dm_W_data;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Per-cycle compare against the model's expectations.
    always @(negedge clk) begin
        check("stall",     {31'd0, stall},       {31'd0, exp_stall});
        check("MemRead",   {31'd0, dm_MemRead},  {31'd0, exp_rd});
        check("MemWrite",  {31'd0, dm_MemWrite}, {31'd0, exp_wr});
        check("ld_valid",  {31'd0, ld_valid},    {31'd0, exp_ldv});
        check("misalign",  {31'd0, misalign},    {31'd0, exp_mis});
        check("ld_data",   ld_data,              exp_ld);
        check("W_addr",    {25'd0, dm_W_addr},   {25'd0, exp_w_addr});
        check("W_data",    dm_W_data,            exp_w_data);
        if (exp_rd) check("R_addr", {25'd0, dm_R_addr}, {25'd0, exp_r_addr});
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_ldv = 1'b0; exp_mis = 1'b0;
        end
    endtask

    // Reference model: decides the access sequence and results from the request alone.
    // Phase codes: 0 accept, 1 read DMEM, 2 write DMEM, 3 respond. abort_wr resets during the write.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [6:0] addr, input logic [31:0] wdata,
                          input logic abort_wr, output logic [31:0] got);
        int          ph[$];
        logic        bad;
        logic [31:0] old, mask, nw, lval;
        int          sh;
        bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        old = model_mem[addr[6:2]];
        sh  = (size == 2'b00) ? 8 * int'(addr[1:0]) : (size == 2'b01) ? 16 * int'(addr[1]) : 0;
        mask = (size == 2'b00) ? (32'h0000_00FF << sh) : (size == 2'b01) ? (32'h0000_FFFF << sh) : 32'hFFFF_FFFF;
        nw   = (old & ~mask) | ((wdata << sh) & mask);
        lval = (old & mask) >> sh;
        if (sgn && size == 2'b00 && lval[7])  lval = lval | 32'hFFFF_FF00;
        if (sgn && size == 2'b01 && lval[15]) lval = lval | 32'hFFFF_0000;
        ph.push_back(0);
        if (!bad) begin
            if (!we) ph.push_back(1);
            else if (size == 2'b10) ph.push_back(2);
            else begin ph.push_back(1); ph.push_back(2); end
        end
        ph.push_back(3);
        got = 32'd0;
        foreach (ph[i]) begin
            @(posedge clk); #1;
            if (ph[i] == 0) begin
                req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
                req_addr = addr; req_wdata = wdata;
            end
            exp_stall = (ph[i] != 3);
            exp_rd    = (ph[i] == 1);
            exp_wr    = (ph[i] == 2);
            exp_ldv   = (ph[i] == 3) && !bad && !we;
            exp_mis   = (ph[i] == 3) && bad;
            if (ph[i] == 1) exp_r_addr = addr;
            if (ph[i] == 2) begin
                exp_w_addr = addr;
                exp_w_data = nw;
            end
            if (exp_ldv) exp_ld = lval;
            @(negedge clk); #1;
            if (ph[i] == 2 && abort_wr) begin
                reset = 1'b1; req_valid = 1'b0;
                exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_ldv = 1'b0; exp_mis = 1'b0;
                exp_w_addr = 7'd0; exp_w_data = 32'd0; exp_ld = 32'd0;
                #1;
                check("abort_MemWrite", {31'd0, dm_MemWrite}, 32'd0);
                check("abort_W_data",   dm_W_data, 32'd0);
                check("abort_ld_data",  ld_data, 32'd0);
                check("abort_stall",    {31'd0, stall}, 32'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            if (ph[i] == 2) model_mem[addr[6:2]] = nw;
            got = ld_data;
        end
    endtask

    task automatic ld_lit(input string name, input logic [1:0] size, input logic sgn,
                          input logic [6:0] addr, input logic [31:0] want);
        logic [31:0] got;
        do_req(1'b0, size, sgn, addr, 32'd0, 1'b0, got);
        check(name, got, want);
        idle(1);
    endtask

    task automatic st(input logic [1:0] size, input logic [6:0] addr, input logic [31:0] wdata);
        logic [31:0] got;
        do_req(1'b1, size, 1'b0, addr, wdata, 1'b0, got);
        idle(1);
    endtask

    initial begin
        logic [31:0] got;
        for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 7'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ld_data",  ld_data, 32'd0);
        check("rst_W_addr",   {25'd0, dm_W_addr}, 32'd0);
        check("rst_MemWrite", {31'd0, dm_MemWrite}, 32'd0);
        reset = 1'b0;
        idle(2);

        // Word store then word load.
        st(2'b10, 7'h08, 32'hDEADBEEF);
        ld_lit("lw_08", 2'b10, 1'b0, 7'h08, 32'hDEADBEEF);

        // Sub-word loads with sign and zero extension.
        st(2'b10, 7'h04, 32'h80FF7F01);
        ld_lit("lb_07",  2'b00, 1'b1, 7'h07, 32'hFFFFFF80);
        ld_lit("lbu_07", 2'b00, 1'b0, 7'h07, 32'h00000080);
        ld_lit("lh_04",  2'b01, 1'b1, 7'h04, 32'h00007F01);
        ld_lit("lhu_06", 2'b01, 1'b0, 7'h06, 32'h000080FF);
        ld_lit("lh_06",  2'b01, 1'b1, 7'h06, 32'hFFFF80FF);
        ld_lit("lb_05",  2'b00, 1'b1, 7'h05, 32'h0000007F);

        // Sub-word stores through read-modify-write.
        st(2'b10, 7'h0C, 32'h11223344);
        st(2'b00, 7'h0D, 32'h000000AA);
        ld_lit("sb_0D", 2'b10, 1'b0, 7'h0C, 32'h1122AA44);
        st(2'b01, 7'h0E, 32'h0000BEEF);
        ld_lit("sh_0E", 2'b10, 1'b0, 7'h0C, 32'hBEEFAA44);
        check("dmem_0C", dmem[3], 32'hBEEFAA44);

        // Top of the address space.
        st(2'b10, 7'h7C, 32'hCAFEF00D);
        st(2'b00, 7'h7F, 32'h00000012);
        ld_lit("lhu_7E", 2'b01, 1'b0, 7'h7E, 32'h000012FE);

        // Illegal requests: no DMEM access, one-cycle stall, misalign pulse.
        ld_lit("lw_0A_ill", 2'b10, 1'b0, 7'h0A, 32'h000012FE);
        st(2'b01, 7'h05, 32'h0000FFFF);
        ld_lit("sz11_ill", 2'b11, 1'b0, 7'h00, 32'h000012FE);
        st(2'b11, 7'h04, 32'h12345678);
        ld_lit("lw_04_kept", 2'b10, 1'b0, 7'h04, 32'h80FF7F01);

        // Back-to-back store then load with req_valid held.
        do_req(1'b1, 2'b10, 1'b0, 7'h10, 32'h12345678, 1'b0, got);
        do_req(1'b0, 2'b10, 1'b0, 7'h10, 32'd0, 1'b0, got);
        check("b2b_lw_10", got, 32'h12345678);
        idle(1);

        // Reset during the write cycle of a byte store leaves memory unchanged.
        st(2'b10, 7'h14, 32'h55555555);
        do_req(1'b1, 2'b00, 1'b0, 7'h15, 32'h000000AA, 1'b1, got);
        idle(2);
        check("abort_dmem_14", dmem[5], 32'h55555555);
        ld_lit("abort_lw_14", 2'b10, 1'b0, 7'h14, 32'h55555555);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
